ts_cc_monitor: RTL and testbench
================================

Name: ts_cc_monitor

Overview:
- Downstream stage of the per-channel TS sync recovery block. Consumes its byte stream (byte_out/valid/sync) and delineates 188-byte packets.
- Parses the 4-byte header and checks the continuity counter (CC) per PID for QoS reporting.
- Reports per-packet header fields, error strobes, and optional statistics counters. One instance per channel.

Parameters:
NUM_PIDS, 4, number of PID entries in the CC tracking table (1..16)
PKT_LEN, 188, TS packet length in bytes, including the sync byte

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-low
byte_in  input  8  TS byte from sync recovery
byte_valid  input  1  byte_in qualifier
sync_in  input  1  high with byte_valid on a locked 0x47 packet-start byte
hdr_valid  output  1  one-cycle strobe; header fields valid
tei  output  1  transport_error_indicator
pusi  output  1  payload_unit_start_indicator
pid  output  13  packet PID
afc  output  2  adaptation_field_control
cc  output  4  continuity_counter
cc_err  output  1  one-cycle strobe with hdr_valid; CC discontinuity
len_err  output  1  one-cycle strobe; packet length violation
table_full  output  1  sticky; a new PID could not be allocated
pkt_count  output  16  packets with a parsed header (TS_STATS_EN)
cc_err_count  output  16  cc_err events (TS_STATS_EN)

Behaviour:
- Reset: rst low at a clk edge. All outputs 0, FSM to HUNT, table entries invalid, byte counter 0.
  - Reset mid-packet discards that packet; no strobes fire.
- Input bytes are consumed only when byte_valid=1. Cycles with byte_valid=0 hold all state. There is no backpressure.
- A start byte is a cycle with byte_valid & sync_in & byte_in==8'h47.
- FSM states: HUNT, HDR1, HDR2, HDR3, PAYLOAD.
  - HUNT: on a start byte -> HDR1, byte_cnt=1. Other bytes are ignored.
  - HDR1: capture tei=b[7], pusi=b[6], pid[12:8]=b[4:0] -> HDR2.
  - HDR2: capture pid[7:0] -> HDR3.
  - HDR3: capture afc=b[5:4], cc=b[3:0]. Perform the table lookup/update on this edge -> PAYLOAD.
  - PAYLOAD: byte_cnt increments per valid byte. When byte_cnt==PKT_LEN-1 is consumed, the next valid byte must be a start byte.
    - Start byte at the expected position -> HDR1, byte_cnt=1.
    - Any other byte there -> len_err pulse, -> HUNT.
  - Start byte in HDR1..PAYLOAD before the expected position: len_err pulse, current packet abandoned, new packet begins -> HDR1. No hdr_valid for the abandoned packet if its header was incomplete.
- Header strobes:
  - hdr_valid and cc_err are registered and assert in the cycle after byte 3 is consumed.
  - Header field outputs hold until the next hdr_valid.
- CC check, applied when hdr_valid fires:
  - PID 0x1FFF (null): not tracked; cc_err=0.
  - tei=1: not checked, table not updated.
  - PID hit, afc in {01,11} (payload present):
    - cc==last+1 mod 16 -> ok; store cc, clear dup flag.
    - cc==last with dup flag clear -> ok (one duplicate allowed); set dup flag.
    - Anything else -> cc_err; store cc, clear dup flag.
  - PID hit, afc in {00,10} (no payload): cc!=last -> cc_err. Stored value unchanged.
  - PID miss: allocate the lowest invalid entry, store cc, no error.
    - Table full: no check, set table_full (sticky until reset).
- Counter arithmetic: 4-bit CC wraps 15->0. pkt_count and cc_err_count saturate at 16'hFFFF.
- len_err and hdr_valid can never coincide with each other in the same cycle by construction; the bench checks this.

Optional Feature:
- Macro TS_STATS_EN.
- Defined: pkt_count increments on every hdr_valid; cc_err_count increments on every cc_err. Both are reset to 0.
- Undefined: counter logic is omitted, and pkt_count and cc_err_count are driven constant 0.

Test Plan:
- Three packets, PID 0x0100, afc=01, cc 0,1,2, byte_valid=1 continuously -> three hdr_valid strobes, one cycle after each byte 3; cc_err=0; pkt_count=3.
- PID 0x0100, cc sequence 5,5,5 with payload -> second packet ok (duplicate), third packet cc_err=1; cc_err_count=1.
- PID 0x0200, cc 14,15,0 with byte_valid toggling 1/0 every cycle -> no cc_err (wrap); hdr_valid one cycle after each byte 3 consumed.
- Start byte arriving at byte index 100 of a packet -> len_err pulse, next header parsed normally. Non-0x47 byte at index 188 -> len_err, FSM to HUNT, no hdr_valid until the next start byte.
- NUM_PIDS=4, five distinct non-null PIDs -> table_full=1 after the fifth header, fifth PID is never flagged. PID 0x1FFF with random cc -> never cc_err.
- rst low for one edge at byte 50 -> all outputs 0. The following start byte parses cleanly; the first packet of each PID does not raise cc_err.

Source files
------------

// File: rtl/ts_cc_monitor.sv
// ts_cc_monitor: delineates TS packets from the sync-recovery byte stream, parses the
// 4-byte header and checks the continuity counter per PID.
// Optional statistics counters (pkt_count, cc_err_count) are built when TS_STATS_EN is
// defined; otherwise both outputs are tied to zero.
module ts_cc_monitor #(
  parameter int unsigned NUM_PIDS = 4,
  parameter int unsigned PKT_LEN  = 188
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        sync_in,
  output logic        hdr_valid,
  output logic        tei,
  output logic        pusi,
  output logic [12:0] pid,
  output logic [1:0]  afc,
  output logic [3:0]  cc,
  output logic        cc_err,
  output logic        len_err,
  output logic        table_full,
  output logic [15:0] pkt_count,
  output logic [15:0] cc_err_count
);

  localparam int unsigned CntW = $clog2(PKT_LEN + 1);
  localparam int unsigned IdxW = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;
  localparam logic [CntW-1:0] PktLenC = CntW'(PKT_LEN);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [12:0]     NullPid = 13'h1FFF;

  typedef enum logic [2:0] {StHunt, StHdr1, StHdr2, StHdr3, StPayload} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] byte_cnt_q, byte_cnt_d;
  logic            tei_sh_q, tei_sh_d, pusi_sh_q, pusi_sh_d;
  logic [12:0]     pid_sh_q, pid_sh_d;
  logic            tei_q, tei_d, pusi_q, pusi_d;
  logic [12:0]     pid_q, pid_d;
  logic [1:0]      afc_q, afc_d;
  logic [3:0]      cc_q, cc_d;
  logic            hdr_valid_q, hdr_valid_d, cc_err_q, cc_err_d, len_err_q, len_err_d;
  logic            table_full_q, table_full_d;
  logic [NUM_PIDS-1:0] ent_valid_q, ent_valid_d, ent_dup_q, ent_dup_d;
  logic [12:0]     ent_pid_q [NUM_PIDS];
  logic [12:0]     ent_pid_d [NUM_PIDS];
  logic [3:0]      ent_cc_q [NUM_PIDS];
  logic [3:0]      ent_cc_d [NUM_PIDS];

  logic            is_start, hit, free;
  logic [IdxW-1:0] hit_idx, free_idx;
  logic [3:0]      last_cc, new_cc;
  logic [1:0]      new_afc;

  assign is_start = byte_valid && sync_in && (byte_in == 8'h47);
  assign new_cc   = byte_in[3:0];
  assign new_afc  = byte_in[5:4];

  // Table lookup for the PID being parsed, plus lowest free entry for allocation.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NUM_PIDS; i++) begin
      if (!hit && ent_valid_q[i] && (ent_pid_q[i] == pid_sh_q)) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
      if (!free && !ent_valid_q[i]) begin
        free     = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // Packet FSM, header capture, CC check and table update.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    tei_sh_d     = tei_sh_q;
    pusi_sh_d    = pusi_sh_q;
    pid_sh_d     = pid_sh_q;
    tei_d        = tei_q;
    pusi_d       = pusi_q;
    pid_d        = pid_q;
    afc_d        = afc_q;
    cc_d         = cc_q;
    hdr_valid_d  = 1'b0;
    cc_err_d     = 1'b0;
    len_err_d    = 1'b0;
    table_full_d = table_full_q;
    ent_valid_d  = ent_valid_q;
    ent_dup_d    = ent_dup_q;
    ent_pid_d    = ent_pid_q;
    ent_cc_d     = ent_cc_q;
    last_cc      = ent_cc_q[hit_idx];

    if (byte_valid) begin
      // A start byte anywhere but HUNT or the expected slot truncates the current packet.
      if (is_start && (state_q != StHunt) &&
          !((state_q == StPayload) && (byte_cnt_q == PktLenC))) begin
        len_err_d = 1'b1;
      end
      if (is_start) begin
        state_d    = StHdr1;
        byte_cnt_d = CntOne;
      end else begin
        case (state_q)
          StHunt: ;
          StHdr1: begin
            tei_sh_d        = byte_in[7];
            pusi_sh_d       = byte_in[6];
            pid_sh_d[12:8]  = byte_in[4:0];
            byte_cnt_d      = byte_cnt_q + CntOne;
            state_d         = StHdr2;
          end
          StHdr2: begin
            pid_sh_d[7:0] = byte_in;
            byte_cnt_d    = byte_cnt_q + CntOne;
            state_d       = StHdr3;
          end
          StHdr3: begin
            tei_d       = tei_sh_q;
            pusi_d      = pusi_sh_q;
            pid_d       = pid_sh_q;
            afc_d       = new_afc;
            cc_d        = new_cc;
            hdr_valid_d = 1'b1;
            byte_cnt_d  = byte_cnt_q + CntOne;
            state_d     = StPayload;
            if ((pid_sh_q != NullPid) && !tei_sh_q) begin
              if (hit) begin
                if (new_afc[0]) begin
                  if (new_cc == last_cc + 4'd1) begin
                    ent_cc_d[hit_idx]  = new_cc;
                    ent_dup_d[hit_idx] = 1'b0;
                  end else if ((new_cc == last_cc) && !ent_dup_q[hit_idx]) begin
                    ent_dup_d[hit_idx] = 1'b1;
                  end else begin
                    cc_err_d           = 1'b1;
                    ent_cc_d[hit_idx]  = new_cc;
                    ent_dup_d[hit_idx] = 1'b0;
                  end
                end else if (new_cc != last_cc) begin
                  // No payload: the counter must not advance; stored value is kept.
                  cc_err_d = 1'b1;
                end
              end else if (free) begin
                ent_valid_d[free_idx] = 1'b1;
                ent_pid_d[free_idx]   = pid_sh_q;
                ent_cc_d[free_idx]    = new_cc;
                ent_dup_d[free_idx]   = 1'b0;
              end else begin
                table_full_d = 1'b1;
              end
            end
          end
          StPayload: begin
            if (byte_cnt_q == PktLenC) begin
              len_err_d  = 1'b1;
              state_d    = StHunt;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + CntOne;
            end
          end
          default: begin
            state_d    = StHunt;
            byte_cnt_d = '0;
          end
        endcase
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StHunt;
      byte_cnt_q   <= '0;
      tei_sh_q     <= 1'b0;
      pusi_sh_q    <= 1'b0;
      pid_sh_q     <= '0;
      tei_q        <= 1'b0;
      pusi_q       <= 1'b0;
      pid_q        <= '0;
      afc_q        <= '0;
      cc_q         <= '0;
      hdr_valid_q  <= 1'b0;
      cc_err_q     <= 1'b0;
      len_err_q    <= 1'b0;
      table_full_q <= 1'b0;
      ent_valid_q  <= '0;
      ent_dup_q    <= '0;
      ent_pid_q    <= '{default: '0};
      ent_cc_q     <= '{default: '0};
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      tei_sh_q     <= tei_sh_d;
      pusi_sh_q    <= pusi_sh_d;
      pid_sh_q     <= pid_sh_d;
      tei_q        <= tei_d;
      pusi_q       <= pusi_d;
      pid_q        <= pid_d;
      afc_q        <= afc_d;
      cc_q         <= cc_d;
      hdr_valid_q  <= hdr_valid_d;
      cc_err_q     <= cc_err_d;
      len_err_q    <= len_err_d;
      table_full_q <= table_full_d;
      ent_valid_q  <= ent_valid_d;
      ent_dup_q    <= ent_dup_d;
      ent_pid_q    <= ent_pid_d;
      ent_cc_q     <= ent_cc_d;
    end
  end

  assign hdr_valid  = hdr_valid_q;
  assign tei        = tei_q;
  assign pusi       = pusi_q;
  assign pid        = pid_q;
  assign afc        = afc_q;
  assign cc         = cc_q;
  assign cc_err     = cc_err_q;
  assign len_err    = len_err_q;
  assign table_full = table_full_q;

`ifdef TS_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d, cc_err_count_q, cc_err_count_d;

  // Saturating statistics counters, updated alongside the strobes they count.
  always_comb begin
    pkt_count_d    = pkt_count_q;
    cc_err_count_d = cc_err_count_q;
    if (hdr_valid_d && (pkt_count_q != 16'hFFFF)) pkt_count_d = pkt_count_q + 16'd1;
    if (cc_err_d && (cc_err_count_q != 16'hFFFF)) cc_err_count_d = cc_err_count_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_count_q    <= '0;
      cc_err_count_q <= '0;
    end else begin
      pkt_count_q    <= pkt_count_d;
      cc_err_count_q <= cc_err_count_d;
    end
  end

  assign pkt_count    = pkt_count_q;
  assign cc_err_count = cc_err_count_q;
`else
  assign pkt_count    = 16'h0000;
  assign cc_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_ts_cc_monitor.sv
// Directed testbench for ts_cc_monitor (NUM_PIDS=4, PKT_LEN=188).
module tb_ts_cc_monitor;

`ifdef TS_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        sync_in;
  logic        hdr_valid, tei, pusi, cc_err, len_err, table_full;
  logic [12:0] pid;
  logic [1:0]  afc;
  logic [3:0]  cc;
  logic [15:0] pkt_count, cc_err_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_hdr  = 0;
  int n_len  = 0;

  bit          gap_mode = 1'b0;
  logic        obs_hv, obs_ce, obs_le;
  logic        le0, hv2, hv3, hv4, ce3, tei3;
  logic [12:0] pid3;
  logic [1:0]  afc3;
  logic [3:0]  cc3;

  ts_cc_monitor #(
    .NUM_PIDS(4),
    .PKT_LEN (188)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .sync_in     (sync_in),
    .hdr_valid   (hdr_valid),
    .tei         (tei),
    .pusi        (pusi),
    .pid         (pid),
    .afc         (afc),
    .cc          (cc),
    .cc_err      (cc_err),
    .len_err     (len_err),
    .table_full  (table_full),
    .pkt_count   (pkt_count),
    .cc_err_count(cc_err_count)
  );

  always #5 clk = ~clk;

  // Strobe counting and exclusivity checks, sampled mid-cycle.
  always @(negedge clk) begin
    if (hdr_valid) n_hdr++;
    if (len_err) n_len++;
    if (hdr_valid || len_err || cc_err) begin
      n_cmp++;
      if ({hdr_valid & len_err, cc_err & ~hdr_valid} !== 2'b00) begin
        n_fail++;
        $display("FAIL strobe_exclusive: hdr_valid=%b len_err=%b cc_err=%b want no overlap",
                 hdr_valid, len_err, cc_err);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic s);
    byte_in    = b;
    sync_in    = s;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    sync_in    = 1'b0;
    obs_hv = hdr_valid;
    obs_ce = cc_err;
    obs_le = len_err;
    if (gap_mode) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends the first len bytes of a packet and records observations at key byte positions.
  task automatic send_pkt(input logic [12:0] p, input logic [1:0] a, input logic [3:0] c,
                          input logic t, input int len);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      case (k)
        0:       b = 8'h47;
        1:       b = {t, 1'b1, 1'b0, p[12:8]};
        2:       b = p[7:0];
        3:       b = {2'b00, a, c};
        default: b = 8'(k);
      endcase
      send_byte(b, k == 0);
      case (k)
        0: le0 = obs_le;
        2: hv2 = obs_hv;
        3: begin
          hv3 = obs_hv; ce3 = obs_ce; pid3 = pid; cc3 = cc; afc3 = afc; tei3 = tei;
        end
        4: hv4 = obs_hv;
        default: ;
      endcase
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    n_cmp++;
    if ({hdr_valid, tei, pusi, pid, afc, cc, cc_err, len_err, table_full, pkt_count,
         cc_err_count} !== 57'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: pid=%h cc=%h tf=%b pkt=%0d got nonzero, want all 0",
               pid, cc, table_full, pkt_count);
    end
  endtask

  task automatic test_basic();
    int h0, l0;
    h0 = n_hdr;
    l0 = n_len;
    gap_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_pkt(13'h100, 2'b01, 4'(i), 1'b0, 188);
      n_cmp++;
      if ({hv2, hv3, hv4, ce3} !== 4'b0100) begin
        n_fail++;
        $display("FAIL basic_timing pkt%0d: hv2/hv3/hv4/ce=%b want 0100", i, {hv2, hv3, hv4, ce3});
      end
      n_cmp++;
      if ({pid3, afc3, cc3} !== {13'h100, 2'b01, 4'(i)}) begin
        n_fail++;
        $display("FAIL basic_fields pkt%0d: pid=%h afc=%b cc=%0d want 100/01/%0d",
                 i, pid3, afc3, cc3, i);
      end
    end
    n_cmp++;
    if ({n_hdr - h0, n_len - l0} !== {32'd3, 32'd0}) begin
      n_fail++;
      $display("FAIL basic_strobe_count: hdr=%0d len=%0d want 3/0", n_hdr - h0, n_len - l0);
    end
    n_cmp++;
    if ({pkt_count, cc_err_count} !== {(StatsEn ? 16'd3 : 16'd0), 16'd0}) begin
      n_fail++;
      $display("FAIL basic_stats: pkt=%0d cce=%0d want %0d/0", pkt_count, cc_err_count,
               StatsEn ? 3 : 0);
    end
  endtask

  task automatic test_dup();
    logic [2:0] exp_ce;
    exp_ce = 3'b100;  // bit i: expected cc_err of packet i
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_pkt(13'h100, 2'b01, 4'd5, 1'b0, 188);
      n_cmp++;
      if ({hv2, hv3, hv4, ce3} !== {3'b010, exp_ce[i]}) begin
        n_fail++;
        $display("FAIL dup_cc pkt%0d: hv2/hv3/hv4/ce=%b want 010%b", i, {hv2, hv3, hv4, ce3},
                 exp_ce[i]);
      end
    end
    n_cmp++;
    if ({pkt_count, cc_err_count} !== (StatsEn ? {16'd3, 16'd1} : 32'd0)) begin
      n_fail++;
      $display("FAIL dup_stats: pkt=%0d cce=%0d want %0d/%0d", pkt_count, cc_err_count,
               StatsEn ? 3 : 0, StatsEn ? 1 : 0);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] ccs [3];
    int h0, l0;
    ccs = '{4'd14, 4'd15, 4'd0};
    h0 = n_hdr;
    l0 = n_len;
    gap_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_pkt(13'h200, 2'b01, ccs[i], 1'b0, 188);
      n_cmp++;
      if ({hv2, hv3, hv4, ce3, pid3, cc3} !== {4'b0100, 13'h200, ccs[i]}) begin
        n_fail++;
        $display("FAIL wrap pkt%0d: hv2/hv3/hv4/ce=%b pid=%h cc=%0d want 0100/200/%0d",
                 i, {hv2, hv3, hv4, ce3}, pid3, cc3, ccs[i]);
      end
    end
    gap_mode = 1'b0;
    n_cmp++;
    if ({n_hdr - h0, n_len - l0} !== {32'd3, 32'd0}) begin
      n_fail++;
      $display("FAIL wrap_strobe_count: hdr=%0d len=%0d want 3/0", n_hdr - h0, n_len - l0);
    end
  endtask

  task automatic test_len_err();
    int h0;
    send_pkt(13'h100, 2'b01, 4'd6, 1'b0, 100);
    n_cmp++;
    if ({le0, hv3, ce3} !== 3'b010) begin
      n_fail++;
      $display("FAIL len_trunc_hdr: le/hv/ce=%b want 010", {le0, hv3, ce3});
    end
    send_pkt(13'h100, 2'b01, 4'd7, 1'b0, 188);
    n_cmp++;
    if ({le0, hv2, hv3, hv4, ce3} !== 5'b10100) begin
      n_fail++;
      $display("FAIL len_early_start: le/hv2/hv3/hv4/ce=%b want 10100", {le0, hv2, hv3, hv4, ce3});
    end
    send_byte(8'h00, 1'b0);
    n_cmp++;
    if (obs_le !== 1'b1) begin
      n_fail++;
      $display("FAIL len_bad_sync: len_err=%b want 1", obs_le);
    end
    h0 = n_hdr;
    send_byte(8'h47, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h18, 1'b0);
    repeat (6) send_byte(8'h55, 1'b0);
    n_cmp++;
    if (n_hdr - h0 !== 0) begin
      n_fail++;
      $display("FAIL len_hunt_quiet: hdr strobes=%0d want 0", n_hdr - h0);
    end
    send_pkt(13'h100, 2'b01, 4'd8, 1'b0, 188);
    n_cmp++;
    if ({le0, hv3, ce3, cc3} !== {3'b010, 4'd8}) begin
      n_fail++;
      $display("FAIL len_resync: le/hv/ce=%b cc=%0d want 010/8", {le0, hv3, ce3}, cc3);
    end
  endtask

  typedef struct packed {
    logic [12:0] p;
    logic [1:0]  a;
    logic [3:0]  c;
    logic        t;
    logic        e;
  } vec_t;

  task automatic test_table_full();
    vec_t v [17];
    v = '{
      '{13'h1FFF, 2'b01, 4'd0, 1'b0, 1'b0}, '{13'h1FFF, 2'b01, 4'd7, 1'b0, 1'b0},
      '{13'h1FFF, 2'b01, 4'd7, 1'b0, 1'b0}, '{13'h1FFF, 2'b01, 4'd7, 1'b0, 1'b0},
      '{13'h0010, 2'b01, 4'd3, 1'b0, 1'b0}, '{13'h0020, 2'b01, 4'd3, 1'b0, 1'b0},
      '{13'h0030, 2'b01, 4'd3, 1'b0, 1'b0}, '{13'h0040, 2'b01, 4'd3, 1'b0, 1'b0},
      '{13'h0050, 2'b01, 4'd3, 1'b0, 1'b0}, '{13'h0050, 2'b01, 4'd9, 1'b0, 1'b0},
      '{13'h0010, 2'b01, 4'd9, 1'b0, 1'b1}, '{13'h0020, 2'b10, 4'd3, 1'b0, 1'b0},
      '{13'h0020, 2'b00, 4'd4, 1'b0, 1'b1}, '{13'h0020, 2'b01, 4'd4, 1'b0, 1'b0},
      '{13'h0030, 2'b01, 4'd0, 1'b1, 1'b0}, '{13'h0030, 2'b01, 4'd4, 1'b0, 1'b0},
      '{13'h1FFF, 2'b11, 4'd2, 1'b0, 1'b0}
    };
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send_pkt(v[i].p, v[i].a, v[i].c, v[i].t, 188);
      n_cmp++;
      if ({hv3, ce3, tei3, pid3, afc3, cc3} !== {1'b1, v[i].e, v[i].t, v[i].p, v[i].a, v[i].c})
      begin
        n_fail++;
        $display("FAIL table_vec%0d: hv=%b ce=%b tei=%b pid=%h cc=%0d want 1/%b/%b/%h/%0d",
                 i, hv3, ce3, tei3, pid3, cc3, v[i].e, v[i].t, v[i].p, v[i].c);
      end
      if (i == 7 || i == 8) begin
        n_cmp++;
        if (table_full !== (i == 8)) begin
          n_fail++;
          $display("FAIL table_full_vec%0d: table_full=%b want %b", i, table_full, i == 8);
        end
      end
    end
    n_cmp++;
    if (table_full !== 1'b1) begin
      n_fail++;
      $display("FAIL table_full_sticky: table_full=%b want 1", table_full);
    end
  endtask

  task automatic test_reset_mid();
    int l0;
    do_reset();
    send_pkt(13'h300, 2'b01, 4'd0, 1'b0, 50);
    do_reset();
    n_cmp++;
    if ({hdr_valid, tei, pusi, pid, afc, cc, cc_err, len_err, table_full, pkt_count,
         cc_err_count} !== 57'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: pid=%h cc=%h pusi=%b got nonzero, want all 0",
               pid, cc, pusi);
    end
    l0 = n_len;
    send_pkt(13'h300, 2'b01, 4'd11, 1'b0, 188);
    n_cmp++;
    if ({le0, hv3, ce3, pid3} !== {3'b010, 13'h300}) begin
      n_fail++;
      $display("FAIL reset_mid_first: le/hv/ce=%b pid=%h want 010/300", {le0, hv3, ce3}, pid3);
    end
    send_pkt(13'h400, 2'b01, 4'd2, 1'b0, 188);
    n_cmp++;
    if ({le0, hv3, ce3, n_len - l0} !== {3'b010, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_second: le/hv/ce=%b len strobes=%0d want 010/0",
               {le0, hv3, ce3}, n_len - l0);
    end
  endtask

  initial begin
    rst        = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    sync_in    = 1'b0;
    test_reset();
    test_basic();
    test_dup();
    test_wrap();
    test_len_err();
    test_table_full();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
